// File: rtl/ppu_oam_dma_if.sv
// Bus bundle for the OAM DMA engine: CPU-side read port, PPU OAM write port and control.
interface ppu_oam_dma_if;
  logic        start;
  logic [7:0]  src_page;
  logic        vblank;
  logic        mem_gnt;
  logic [7:0]  mem_rdata;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [3:0]  oam_we;
  logic [5:0]  oam_w_addr;
  logic [31:0] oam_data_in;
  logic        busy;
  logic        done;

  modport master (
    input  start, src_page, vblank, mem_gnt, mem_rdata,
    output mem_addr, mem_rd, oam_we, oam_w_addr, oam_data_in, busy, done
  );

  modport slave (
    output start, src_page, vblank, mem_gnt, mem_rdata,
    input  mem_addr, mem_rd, oam_we, oam_w_addr, oam_data_in, busy, done
  );
endinterface

// File: rtl/ppu_oam_dma.sv
// Copies NUM_SPRITES*4 bytes from a CPU memory page into PPU sprite OAM, one packed word per sprite.
module ppu_oam_dma #(
  parameter int NUM_SPRITES = 64,
  parameter bit WAIT_VBLANK = 1'b1
) (
  input logic           clk,
  input logic           rst,
  ppu_oam_dma_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    REQ    = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    FINISH = 3'd5
  } state_t;

  localparam logic [7:0] LAST_BYTE = 8'(NUM_SPRITES * 4 - 1);

  state_t      state_r, state_s;
  logic [7:0]  page_r, page_s;
  logic [7:0]  b_r, b_s;
  logic [31:0] pack_r, pack_s;
  logic        busy_r, mem_rd_r, done_r;
  logic [3:0]  oam_we_r;

  // Next-state, byte counter and pack-lane update
  always_comb begin
    state_s = state_r;
    page_s  = page_r;
    b_s     = b_r;
    pack_s  = pack_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          page_s  = bus.src_page;
          b_s     = 8'd0;
          state_s = SYNC;
        end else begin
          state_s = IDLE;
        end
      end
      SYNC: begin
        if ((WAIT_VBLANK == 1'b0) || bus.vblank) begin
          state_s = REQ;
        end else begin
          state_s = SYNC;
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          state_s = DATA;
        end else begin
          state_s = REQ;
        end
      end
      DATA: begin
        case (b_r[1:0])
          2'd0:    pack_s[7:0]   = bus.mem_rdata;
          2'd1:    pack_s[15:8]  = bus.mem_rdata;
          2'd2:    pack_s[23:16] = bus.mem_rdata;
          2'd3:    pack_s[31:24] = bus.mem_rdata;
          default: pack_s        = pack_r;
        endcase
        if (b_r[1:0] == 2'd3) begin
          state_s = WRITE;
        end else begin
          b_s     = b_r + 8'd1;
          state_s = REQ;
        end
      end
      WRITE: begin
        // b stays on the last lane so oam_w_addr = b[7:2] names this sprite
        if (b_r == LAST_BYTE) begin
          state_s = FINISH;
        end else begin
          b_s     = b_r + 8'd1;
          state_s = REQ;
        end
      end
      FINISH: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and output flag registers; flags are decoded from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      page_r   <= 8'd0;
      b_r      <= 8'd0;
      pack_r   <= 32'd0;
      busy_r   <= 1'b0;
      mem_rd_r <= 1'b0;
      done_r   <= 1'b0;
      oam_we_r <= 4'h0;
    end else begin
      state_r  <= state_s;
      page_r   <= page_s;
      b_r      <= b_s;
      pack_r   <= pack_s;
      busy_r   <= (state_s != IDLE);
      mem_rd_r <= (state_s == REQ);
      done_r   <= (state_s == FINISH);
      oam_we_r <= (state_s == WRITE) ? 4'hF : 4'h0;
    end
  end

  assign bus.mem_addr    = {page_r, b_r};
  assign bus.mem_rd      = mem_rd_r;
  assign bus.oam_we      = oam_we_r;
  assign bus.oam_w_addr  = b_r[7:2];
  assign bus.oam_data_in = pack_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Scoreboard bench for ppu_oam_dma: a 64-sprite vblank-gated instance and an 8-sprite free-running one.
module tb_ppu_oam_dma;

  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   rnd_gnt     = 1'b0;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_a[$];
  wr_t         exp_b[$];
  logic [31:0] shadow_a[64];
  logic [31:0] shadow_b[64];
  int          wr_cnt_a   = 0;
  int          wr_cnt_b   = 0;
  int          done_cnt_a = 0;
  int          done_cnt_b = 0;

  ppu_oam_dma_if bus_a();
  ppu_oam_dma_if bus_b();

  ppu_oam_dma #(.NUM_SPRITES(64), .WAIT_VBLANK(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  ppu_oam_dma #(.NUM_SPRITES(8),  .WAIT_VBLANK(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Page 0x02 holds n at offset n; other pages hold a scrambled pattern
  function automatic logic [7:0] mb(input logic [15:0] addr);
    return (addr[15:8] == 8'h02) ? addr[7:0] : (addr[7:0] ^ addr[15:8] ^ 8'h5A);
  endfunction

  function automatic logic [31:0] exp_word(input logic [7:0] page, input int k);
    logic [7:0] base;
    base = 8'(4 * k);
    return {mb({page, base + 8'd3}), mb({page, base + 8'd2}), mb({page, base + 8'd1}), mb({page, base})};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_busy"},   32'(bus_a.busy),        32'd0);
    check({tag, "_mem_rd"}, 32'(bus_a.mem_rd),      32'd0);
    check({tag, "_done"},   32'(bus_a.done),        32'd0);
    check({tag, "_we"},     32'(bus_a.oam_we),      32'd0);
    check({tag, "_addr"},   32'(bus_a.mem_addr),    32'd0);
    check({tag, "_waddr"},  32'(bus_a.oam_w_addr),  32'd0);
    check({tag, "_wdata"},  bus_a.oam_data_in,      32'd0);
  endtask

  task automatic start_a(input logic [7:0] page);
    for (int k = 0; k < 64; k++) exp_a.push_back('{addr: 6'(k), data: exp_word(page, k)});
    @(negedge clk);
    bus_a.src_page = page;
    bus_a.start    = 1'b1;
    @(negedge clk);
    bus_a.start    = 1'b0;
    bus_a.src_page = 8'h00;
  endtask

  task automatic wait_done_a(input int limit, output int cyc, output int busy_low);
    cyc      = 1;
    busy_low = 0;
    while (bus_a.done !== 1'b1 && cyc < limit) begin
      if (bus_a.busy !== 1'b1) busy_low++;
      @(negedge clk);
      cyc++;
    end
  endtask

  // Memory models: data appears the cycle after a granted request, garbage otherwise
  always @(posedge clk) begin
    bus_a.mem_rdata <= (bus_a.mem_rd && bus_a.mem_gnt) ? mb(bus_a.mem_addr) : 8'hEE;
    bus_b.mem_rdata <= (bus_b.mem_rd && bus_b.mem_gnt) ? mb(bus_b.mem_addr) : 8'hEE;
  end

  initial begin
    forever begin
      @(negedge clk);
      bus_a.mem_gnt = rnd_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
      bus_b.mem_gnt = 1'b1;
    end
  end

  // Monitor A: write scoreboard, done counter and request-hold checks
  initial begin
    wr_t         e;
    logic        prev_rd;
    logic [15:0] prev_addr;
    prev_rd   = 1'b0;
    prev_addr = 16'd0;
    forever begin
      @(posedge clk);
      #1;
      if (prev_rd && !bus_a.mem_gnt) begin
        check("a_rd_held", 32'(bus_a.mem_rd), 32'd1);
        check("a_addr_stable", 32'(bus_a.mem_addr), 32'(prev_addr));
      end else if (prev_rd) begin
        check("a_rd_drop", 32'(bus_a.mem_rd), 32'd0);
      end
      prev_rd   = bus_a.mem_rd;
      prev_addr = bus_a.mem_addr;
      if (bus_a.done) done_cnt_a++;
      if (bus_a.oam_we != 4'h0) begin
        wr_cnt_a++;
        shadow_a[bus_a.oam_w_addr] = bus_a.oam_data_in;
        check("a_we", 32'(bus_a.oam_we), 32'hF);
        check("a_write_expected", 32'(exp_a.size() != 0), 32'd1);
        if (exp_a.size() != 0) begin
          e = exp_a.pop_front();
          check("a_waddr", 32'(bus_a.oam_w_addr), 32'(e.addr));
          check("a_wdata", bus_a.oam_data_in, e.data);
        end
      end
    end
  end

  // Monitor B: write scoreboard and done counter
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus_b.done) done_cnt_b++;
      if (bus_b.oam_we != 4'h0) begin
        wr_cnt_b++;
        shadow_b[bus_b.oam_w_addr] = bus_b.oam_data_in;
        check("b_we", 32'(bus_b.oam_we), 32'hF);
        check("b_write_expected", 32'(exp_b.size() != 0), 32'd1);
        if (exp_b.size() != 0) begin
          e = exp_b.pop_front();
          check("b_waddr", 32'(bus_b.oam_w_addr), 32'(e.addr));
          check("b_wdata", bus_b.oam_data_in, e.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog: time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, busy_low, wbase, dbase, lim, rd_seen;
    for (int k = 0; k < 64; k++) begin
      shadow_a[k] = 32'hDEADBEEF;
      shadow_b[k] = 32'hDEADBEEF;
    end
    rst            = 1'b0;
    bus_a.start    = 1'b0;
    bus_a.src_page = 8'h00;
    bus_a.vblank   = 1'b1;
    bus_a.mem_gnt  = 1'b1;
    bus_b.start    = 1'b0;
    bus_b.src_page = 8'h00;
    bus_b.vblank   = 1'b0;
    bus_b.mem_gnt  = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_a("reset");
    check("reset_b_busy", 32'(bus_b.busy), 32'd0);
    check("reset_b_addr", 32'(bus_b.mem_addr), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic copy of page 0x02 with constant grant
    wbase = wr_cnt_a;
    start_a(8'h02);
    wait_done_a(2000, cyc, busy_low);
    check("t1_latency", 32'(cyc), 32'd578);
    check("t1_busy_low", 32'(busy_low), 32'd0);
    @(negedge clk);
    check("t1_done_pulse", 32'(bus_a.done), 32'd0);
    check("t1_busy_clear", 32'(bus_a.busy), 32'd0);
    check("t1_writes", 32'(wr_cnt_a - wbase), 32'd64);
    check("t1_pending", 32'(exp_a.size()), 32'd0);
    check("t1_word0", shadow_a[0], 32'h03020100);
    check("t1_word63", shadow_a[63], 32'hFFFEFDFC);

    // Start while vblank is low, then drop vblank mid-copy
    bus_a.vblank = 1'b0;
    wbase = wr_cnt_a;
    start_a(8'h37);
    rd_seen = 0;
    repeat (20) begin
      if (bus_a.mem_rd) rd_seen++;
      @(negedge clk);
    end
    check("t2_no_rd_before_vblank", 32'(rd_seen), 32'd0);
    check("t2_busy_waiting", 32'(bus_a.busy), 32'd1);
    bus_a.vblank = 1'b1;
    @(posedge clk);
    #1;
    check("t2_rd_after_vblank", 32'(bus_a.mem_rd), 32'd1);
    check("t2_first_addr", 32'(bus_a.mem_addr), 32'h3700);
    repeat (50) @(negedge clk);
    bus_a.vblank = 1'b0;
    wait_done_a(2000, cyc, busy_low);
    check("t2_done", 32'(bus_a.done), 32'd1);
    @(negedge clk);
    check("t2_writes", 32'(wr_cnt_a - wbase), 32'd64);
    check("t2_pending", 32'(exp_a.size()), 32'd0);
    bus_a.vblank = 1'b1;

    // Random grant: contents must match the first copy
    for (int k = 0; k < 64; k++) shadow_a[k] = 32'hDEADBEEF;
    rnd_gnt = 1'b1;
    start_a(8'h02);
    wait_done_a(5000, cyc, busy_low);
    check("t3_done", 32'(bus_a.done), 32'd1);
    check("t3_busy_low", 32'(busy_low), 32'd0);
    rnd_gnt = 1'b0;
    @(negedge clk);
    check("t3_pending", 32'(exp_a.size()), 32'd0);
    check("t3_word0", shadow_a[0], 32'h03020100);
    check("t3_word17", shadow_a[17], 32'h47464544);
    check("t3_word63", shadow_a[63], 32'hFFFEFDFC);

    // A second start during a busy transfer is ignored
    wbase = wr_cnt_a;
    dbase = done_cnt_a;
    start_a(8'h02);
    repeat (98) @(negedge clk);
    bus_a.src_page = 8'h05;
    bus_a.start    = 1'b1;
    @(negedge clk);
    bus_a.start    = 1'b0;
    wait_done_a(2000, cyc, busy_low);
    repeat (700) @(negedge clk);
    check("t4_done_count", 32'(done_cnt_a - dbase), 32'd1);
    check("t4_writes", 32'(wr_cnt_a - wbase), 32'd64);
    check("t4_pending", 32'(exp_a.size()), 32'd0);

    // Reset after 10 words: immediate zero outputs, no done, then a clean copy
    wbase = wr_cnt_a;
    dbase = done_cnt_a;
    start_a(8'h02);
    lim = 0;
    while ((wr_cnt_a - wbase) < 10 && lim < 500) begin
      @(negedge clk);
      lim++;
    end
    rst = 1'b0;
    #1;
    check_zero_a("t5_abort");
    exp_a.delete();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    check("t5_writes_before_reset", 32'(wr_cnt_a - wbase), 32'd10);
    check("t5_no_done", 32'(done_cnt_a - dbase), 32'd0);
    start_a(8'h11);
    wait_done_a(2000, cyc, busy_low);
    check("t5_latency", 32'(cyc), 32'd578);
    @(negedge clk);
    check("t5_pending", 32'(exp_a.size()), 32'd0);

    // 8-sprite instance without vblank gating: OAM word 8 untouched
    for (int k = 0; k < 8; k++) exp_b.push_back('{addr: 6'(k), data: exp_word(8'h02, k)});
    @(negedge clk);
    bus_b.src_page = 8'h02;
    bus_b.start    = 1'b1;
    @(negedge clk);
    bus_b.start    = 1'b0;
    cyc = 1;
    while (bus_b.done !== 1'b1 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_latency", 32'(cyc), 32'd74);
    repeat (20) @(negedge clk);
    check("t6_writes", 32'(wr_cnt_b), 32'd8);
    check("t6_done_count", 32'(done_cnt_b), 32'd1);
    check("t6_pending", 32'(exp_b.size()), 32'd0);
    check("t6_word7", shadow_b[7], 32'h1F1E1D1C);
    check("t6_word8_untouched", shadow_b[8], 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
